// File: rtl/shift_pkg.sv
// Shared encodings for the pipelined shift unit: operation modes and their width.
package shift_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t SH_SRL = 2'b00;
  localparam mode_t SH_SRA = 2'b01;
  localparam mode_t SH_SLL = 2'b10;
  localparam mode_t SH_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// Single fixed-amount shifter/rotator: one log2 step of the barrel shifter.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned AMOUNT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  input  logic             en,
  output logic [WIDTH-1:0] result_c
);

  // SRA replicates the current MSB; right shifts never change it, so it is the original sign.
  always_comb begin
    result_c = data;
    if (en) begin
      case (mode)
        SH_SRL:  result_c = {{AMOUNT{1'b0}}, data[WIDTH-1:AMOUNT]};
        SH_SRA:  result_c = {{AMOUNT{data[WIDTH-1]}}, data[WIDTH-1:AMOUNT]};
        SH_SLL:  result_c = {data[WIDTH-AMOUNT-1:0], {AMOUNT{1'b0}}};
        default: result_c = {data[AMOUNT-1:0], data[WIDTH-1:AMOUNT]};
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides; stage k shifts by 2^k
// when distance bit k is set, one register per stage, bubble-collapsing flow control.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned DISTW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  mode_t            in_mode,
  input  logic [DISTW-1:0] in_dist,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int unsigned LAST = DISTW - 1;

  // Per-stage inputs (from the port for stage 0, else from the previous register)
  logic [WIDTH-1:0] src_data  [DISTW];
  mode_t            src_mode  [DISTW];
  logic [DISTW-1:0] src_dist  [DISTW];
  logic [DISTW-1:0] src_valid;
  logic [WIDTH-1:0] nxt_data  [DISTW];
  logic [DISTW-1:0] load_c;
  logic             zero_c;

  // Intermediate stage registers; the last stage is the output register itself
  logic [WIDTH-1:0] data_q    [LAST];
  mode_t            mode_q    [LAST];
  logic [DISTW-1:0] dist_q    [LAST];
  logic [LAST-1:0]  valid_q;

  for (genvar k = 0; k < DISTW; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_data[k]  = in_data;
      assign src_mode[k]  = in_mode;
      assign src_dist[k]  = in_dist;
      assign src_valid[k] = in_valid;
    end else begin : g_body
      assign src_data[k]  = data_q[k-1];
      assign src_mode[k]  = mode_q[k-1];
      assign src_dist[k]  = dist_q[k-1];
      assign src_valid[k] = valid_q[k-1];
    end

    shift_stage #(
      .WIDTH  (WIDTH),
      .AMOUNT (1 << k)
    ) u_stage (
      .data     (src_data[k]),
      .mode     (src_mode[k]),
      .en       (src_dist[k][k]),
      .result_c (nxt_data[k])
    );
  end

  // A stage loads when empty or when its successor loads from it; the chain ends at out_ready.
  always_comb begin : p_load
    logic take;
    take         = !out_valid | out_ready;
    load_c       = '0;
    load_c[LAST] = take;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      take      = !valid_q[k] | take;
      load_c[k] = take;
    end
  end

  assign in_ready = load_c[0];
  assign zero_c   = (nxt_data[LAST] == '0);

  // Payload only moves with a valid beat, so idle X on the inputs never enters the pipe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < int'(LAST); k++) begin
        data_q[k] <= '0;
        mode_q[k] <= SH_SRL;
        dist_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(LAST); k++) begin
        if (load_c[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            data_q[k] <= nxt_data[k];
            mode_q[k] <= src_mode[k];
            dist_q[k] <= src_dist[k];
          end
        end
      end
    end
  end

  // Output register: final stage result plus its zero flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
    end else if (load_c[LAST]) begin
      out_valid <= src_valid[LAST];
      if (src_valid[LAST]) begin
        out_data <= nxt_data[LAST];
        out_zero <= zero_c;
      end
    end
  end

endmodule
